uart_rx_core: RTL

- Synthesizable UART receiver; the RTL counterpart of the bench-side UART agent receive path.
- Samples the asynchronous serial line `rx` (8N1, LSB first) using a 16x oversampled baud tick.
- Delivers each received byte on a valid/ready stream interface.
- Flags framing and overrun errors; sits behind the device pad and feeds the command/data decoder.

---
 rtl/uart_rx_core.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// 16x-oversampled 8N1 UART receiver with a valid/ready byte output and framing/overrun flags.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit and the parity_err output.
module uart_rx_core #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUDRATE   = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   localparam int DIV_RAW = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DW      = $clog2(DIV + 1);
   localparam int SW      = $clog2(OVERSAMPLE);

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [SW-1:0] SC_LAST  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] SC_V0    = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SC_V1    = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] SC_V2    = SW'(OVERSAMPLE / 2 + 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] STOP   = 3'd3;
   localparam logic [2:0] BRK    = 3'd4;
`ifdef UART_RX_PARITY_EN
   localparam logic [2:0] PARITY = 3'd5;
`endif

   logic [2:0]    state;
   logic          rx_meta;
   logic          rxs;
   logic [DW-1:0] div_cnt;
   logic [SW-1:0] sc;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          s0;
   logic          s1;
   logic          tick;
   logic          wrap;
   logic          vote_now;
   logic          vote;
`ifdef UART_RX_PARITY_EN
   logic          par_bad;
`endif

   assign tick     = (div_cnt == DIV_LAST);
   assign wrap     = tick && (sc == SC_LAST);
   assign vote_now = tick && (sc == SC_V2);
   // Majority of the three mid-bit samples; the third is the live synchronized line.
   assign vote     = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
   assign busy     = (state != IDLE);

   // Output stream: a byte moves on every cycle with valid & ready both high. valid
   // is held (data frozen) until that happens; a transfer drops valid the following
   // cycle unless a newly completed byte loads on the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rx_meta   <= 1'b1;
         rxs       <= 1'b1;
         div_cnt   <= '0;
         sc        <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         s0        <= 1'b1;
         s1        <= 1'b1;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         rx_meta   <= rx;
         rxs       <= rx_meta;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         div_cnt <= tick ? '0 : div_cnt + DW'(1);
         if (tick) sc <= wrap ? '0 : sc + SW'(1);
         if (tick && sc == SC_V0) s0 <= rxs;
         if (tick && sc == SC_V1) s1 <= rxs;
         if (valid && ready) valid <= 1'b0;

         case (state)
            IDLE: begin
               if (!rxs) begin
                  // Restart the divider so sampling phase follows the start edge.
                  state   <= START;
                  div_cnt <= '0;
                  sc      <= '0;
               end
            end
            START: begin
               if (vote_now && vote) begin
                  state <= IDLE;
               end else if (wrap) begin
                  state   <= DATA;
                  bit_idx <= '0;
               end
            end
            DATA: begin
               if (vote_now) shreg <= {vote, shreg[7:1]};
               if (wrap) begin
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (vote_now) par_bad <= vote ^ (^shreg);
               if (wrap) state <= STOP;
            end
`endif
            STOP: begin
               if (vote_now) begin
                  if (!vote) begin
                     frame_err <= 1'b1;
                     state     <= BRK;
                  end else begin
                     state <= IDLE;
`ifdef UART_RX_PARITY_EN
                     if (par_bad) parity_err <= 1'b1;
                     else if (valid && !ready) overrun <= 1'b1;
`else
                     if (valid && !ready) overrun <= 1'b1;
`endif
                     else begin
                        data  <= shreg;
                        valid <= 1'b1;
                     end
                  end
               end
            end
            BRK: begin
               if (rxs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
